// File: rtl/alu_unit.sv
// alu_unit: WIDTH-bit execute-stage ALU for the teaching CPU.
// Supports ADD, SUB, AND, XOR and signed set-less-than. The result and the
// overflow and carry flags are registered, so they appear one edge after the
// operands are sampled.
// Optional feature: define ALU_ZERO_FLAG_EN to add the registered 'zero' port.
// The zero flag is 1 whenever the registered result is zero.

module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
`ifdef ALU_ZERO_FLAG_EN
  output logic             carry,
  output logic             zero
`else
  output logic             carry
`endif
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_SLT = 3'b101
  } alu_op_e;

  localparam int MSB = WIDTH - 1;

  logic             do_sub;
  logic [WIDTH-1:0] b_operand;
  logic [WIDTH:0]   adder_out;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             adder_overflow;
  logic             less_than;
  logic [WIDTH-1:0] next_result;
  logic             next_overflow;
  logic             next_carry;

  // The shared adder subtracts as a + ~b + 1. SLT reuses that subtraction,
  // so the less-than decision comes from the same hardware as SUB.
  always_comb begin
    do_sub         = (alu_control == OP_SUB) || (alu_control == OP_SLT);
    b_operand      = do_sub ? ~b : b;
    adder_out      = {1'b0, a} + {1'b0, b_operand} + {{WIDTH{1'b0}}, do_sub};
    sum            = adder_out[WIDTH-1:0];
    cout           = adder_out[WIDTH];
    // Comparing against the adder's actual second operand covers the add and
    // subtract overflow rules with a single expression.
    adder_overflow = (a[MSB] == b_operand[MSB]) && (sum[MSB] != a[MSB]);
    less_than      = sum[MSB] ^ adder_overflow;
  end

  // Choose the next result and flags. Only ADD and SUB report overflow and
  // carry. Reserved codes produce all zeros.
  always_comb begin
    next_result   = '0;
    next_overflow = 1'b0;
    next_carry    = 1'b0;
    case (alu_control)
      OP_ADD, OP_SUB: begin
        next_result   = sum;
        next_overflow = adder_overflow;
        next_carry    = cout;
      end
      OP_AND: next_result = a & b;
      OP_XOR: next_result = a ^ b;
      OP_SLT: next_result = {{(WIDTH-1){1'b0}}, less_than};
      default: next_result = '0;
    endcase
  end

`ifdef ALU_ZERO_FLAG_EN
  // Register the result, the flags and the zero flag. Reset clears them at
  // once, and the zero flag resets to 1 to match the cleared result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      zero     <= 1'b1;
    end else begin
      result   <= next_result;
      overflow <= next_overflow;
      carry    <= next_carry;
      zero     <= (next_result == '0);
    end
  end
`else
  // Register the result and the flags. Reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
      carry    <= 1'b0;
    end else begin
      result   <= next_result;
      overflow <= next_overflow;
      carry    <= next_carry;
    end
  end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: self-checking bench for alu_unit at WIDTH=32.
// Each expected result is pushed to a scoreboard queue when its operands are
// driven. It is popped and compared when the registered output shows up.
// Directed vectors carry hand-computed expectations. The random stream uses
// an independent arithmetic model.

module tb_alu_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry;
`ifdef ALU_ZERO_FLAG_EN
  logic             zero;
`endif

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             cy;
  } exp_t;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctl;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             cy;
  } vec_t;

  exp_t scoreboard[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .result      (result),
    .overflow    (overflow),
`ifdef ALU_ZERO_FLAG_EN
    .carry       (carry),
    .zero        (zero)
`else
    .carry       (carry)
`endif
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model built on wide signed and unsigned arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic [2:0] ctl);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      s;
    logic [32:0] wide;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    e.tag = "random";
    e.res = '0;
    e.ovf = 1'b0;
    e.cy  = 1'b0;
    case (ctl)
      3'd0: begin
        e.res = x + y;
        s     = sx + sy;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        wide  = {1'b0, x} + {1'b0, y};
        e.cy  = wide[32];
      end
      3'd1: begin
        e.res = x - y;
        s     = sx - sy;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.cy  = (x >= y);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x ^ y;
      3'd5: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Drive one operation and record what it should produce one edge later.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    a           = v.a;
    b           = v.b;
    alu_control = v.ctl;
    e.tag       = v.tag;
    e.res       = v.res;
    e.ovf       = v.ovf;
    e.cy        = v.cy;
    scoreboard.push_back(e);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    a           = 32'd10;
    b           = 32'd5;
    alu_control = 3'b000;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result !== 32'd0) $display("[TB] FAIL reset_result got %h expected %h", result, 32'd0);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow got %b expected 0", overflow);
    else n_pass++;
    n_checks++;
    if (carry !== 1'b0) $display("[TB] FAIL reset_carry got %b expected 0", carry);
    else n_pass++;
`ifdef ALU_ZERO_FLAG_EN
    n_checks++;
    if (zero !== 1'b1) $display("[TB] FAIL reset_zero got %b expected 1", zero);
    else n_pass++;
`endif
    rst_n = 1'b1;
  endtask

  // Run a list of directed vectors, one at a time, each checked one edge later.
  task automatic test_directed(input vec_t vq[$]);
    exp_t e;
    foreach (vq[i]) begin
      @(negedge clk);
      applyStimulus(vq[i]);
      @(negedge clk);
      e = scoreboard.pop_front();
      n_checks++;
      if (result !== e.res) $display("[TB] FAIL %s result got %h expected %h", e.tag, result, e.res);
      else n_pass++;
      n_checks++;
      if (overflow !== e.ovf) $display("[TB] FAIL %s overflow got %b expected %b", e.tag, overflow, e.ovf);
      else n_pass++;
      n_checks++;
      if (carry !== e.cy) $display("[TB] FAIL %s carry got %b expected %b", e.tag, carry, e.cy);
      else n_pass++;
`ifdef ALU_ZERO_FLAG_EN
      n_checks++;
      if (zero !== (e.res == '0)) $display("[TB] FAIL %s zero got %b expected %b", e.tag, zero, (e.res == '0));
      else n_pass++;
`endif
    end
  endtask

  task automatic test_arith();
    vec_t vq[$];
    vq.push_back('{"add_10_5",     32'd10,         32'd5, 3'b000, 32'd15,         1'b0, 1'b0});
    vq.push_back('{"sub_10_5",     32'd10,         32'd5, 3'b001, 32'd5,          1'b0, 1'b1});
    vq.push_back('{"sub_min_1",    32'h8000_0000,  32'd1, 3'b001, 32'h7FFF_FFFF,  1'b1, 1'b1});
    vq.push_back('{"sub_borrow",   32'd5,          32'd10, 3'b001, 32'hFFFF_FFFB, 1'b0, 1'b0});
    vq.push_back('{"add_max_1",    32'h7FFF_FFFF,  32'd1, 3'b000, 32'h8000_0000,  1'b1, 1'b0});
    vq.push_back('{"add_wrap",     32'hFFFF_FFFF,  32'd1, 3'b000, 32'h0000_0000,  1'b0, 1'b1});
    test_directed(vq);
  endtask

  task automatic test_logic();
    vec_t vq[$];
    vq.push_back('{"and_f0f0",  32'hF0F0, 32'hFF00, 3'b010, 32'h0000_F000, 1'b0, 1'b0});
    vq.push_back('{"xor_f0f0",  32'hF0F0, 32'hFF00, 3'b011, 32'h0000_0FF0, 1'b0, 1'b0});
    vq.push_back('{"rsvd_111",  32'hFFFF_FFFF, 32'd1, 3'b111, 32'd0, 1'b0, 1'b0});
    vq.push_back('{"rsvd_100",  32'h7FFF_FFFF, 32'd1, 3'b100, 32'd0, 1'b0, 1'b0});
    test_directed(vq);
  endtask

  task automatic test_slt();
    vec_t vq[$];
    vq.push_back('{"slt_5_10",    32'd5,         32'd10,        3'b101, 32'd1, 1'b0, 1'b0});
    vq.push_back('{"slt_10_10",   32'd10,        32'd10,        3'b101, 32'd0, 1'b0, 1'b0});
    vq.push_back('{"slt_neg5_10", 32'hFFFF_FFFB, 32'd10,        3'b101, 32'd1, 1'b0, 1'b0});
    vq.push_back('{"slt_10_neg5", 32'd10,        32'hFFFF_FFFB, 3'b101, 32'd0, 1'b0, 1'b0});
    vq.push_back('{"slt_min_1",   32'h8000_0000, 32'd1,         3'b101, 32'd1, 1'b0, 1'b0});
    test_directed(vq);
  endtask

  // New operation every cycle. Each output is compared as the next op is driven.
  task automatic test_back_to_back();
    exp_t        e;
    vec_t        v;
    exp_t        m;
    logic [31:0] pool [8];
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0001; pool[2] = 32'h7FFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'hFFFF_FFFF; pool[5] = 32'h0000_000A;
    pool[6] = 32'hFFFF_FFFB; pool[7] = 32'h1234_5678;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = scoreboard.pop_front();
        n_checks++;
        if (result !== e.res) $display("[TB] FAIL b2b_%0d result got %h expected %h", i, result, e.res);
        else n_pass++;
        n_checks++;
        if (overflow !== e.ovf) $display("[TB] FAIL b2b_%0d overflow got %b expected %b", i, overflow, e.ovf);
        else n_pass++;
        n_checks++;
        if (carry !== e.cy) $display("[TB] FAIL b2b_%0d carry got %b expected %b", i, carry, e.cy);
        else n_pass++;
`ifdef ALU_ZERO_FLAG_EN
        n_checks++;
        if (zero !== (e.res == '0)) $display("[TB] FAIL b2b_%0d zero got %b expected %b", i, zero, (e.res == '0));
        else n_pass++;
`endif
      end
      if (i < 24) begin
        v.tag = "b2b";
        v.a   = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
        v.b   = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
        v.ctl = 3'($urandom_range(0, 7));
        m     = model(v.a, v.b, v.ctl);
        v.res = m.res;
        v.ovf = m.ovf;
        v.cy  = m.cy;
        applyStimulus(v);
      end
    end
  endtask

  // Reset asserted between edges must clear the outputs immediately.
  task automatic test_async_reset();
    @(negedge clk);
    a           = 32'h7FFF_FFFF;
    b           = 32'd1;
    alu_control = 3'b000;
    @(posedge clk);
    #2;
    n_checks++;
    if (result !== 32'h8000_0000 || overflow !== 1'b1)
      $display("[TB] FAIL pre_reset got %h/%b expected 80000000/1", result, overflow);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (result !== 32'd0) $display("[TB] FAIL async_reset_result got %h expected 0", result);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0 || carry !== 1'b0)
      $display("[TB] FAIL async_reset_flags got %b%b expected 00", overflow, carry);
    else n_pass++;
`ifdef ALU_ZERO_FLAG_EN
    n_checks++;
    if (zero !== 1'b1) $display("[TB] FAIL async_reset_zero got %b expected 1", zero);
    else n_pass++;
`endif
    @(negedge clk);
    n_checks++;
    if (result !== 32'd0) $display("[TB] FAIL reset_held got %h expected 0", result);
    else n_pass++;
    rst_n = 1'b1;
    a     = 32'd10;
    b     = 32'd5;
    @(negedge clk);
    n_checks++;
    if (result !== 32'd15) $display("[TB] FAIL first_after_reset got %h expected %h", result, 32'd15);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_slt();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
